// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Sequences single commands through an external combinational ALU.
//            A command is accepted in IDLE, the operands and select are
//            registered onto the ALU for one EXEC cycle, and the ALU results
//            are captured and presented on a valid/ready response channel
//            in RESP. Completed responses are counted in op_count.
// Ports    : clk, rst_n                - clock, asynchronous active-low reset
//            req_valid/req_ready       - command handshake
//            req_a, req_b, req_op      - operands and ALU select
//            alu_a, alu_b, alu_select  - registered drive to the ALU
//            alu_out, alu_carry,
//            alu_greater/equal/less    - ALU results
//            rsp_valid/rsp_ready       - response handshake
//            rsp_data/carry/zero/err/cmp - captured response
//            op_count                  - completed response counter (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WIDTH-1:0]     req_a,
    input  logic [WIDTH-1:0]     req_b,
    input  logic [2:0]           req_op,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [2:0]           alu_select,
    input  logic [2*WIDTH-1:0]   alu_out,
    input  logic                 alu_carry,
    input  logic                 alu_greater,
    input  logic                 alu_equal,
    input  logic                 alu_less,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*WIDTH-1:0]   rsp_data,
    output logic                 rsp_carry,
    output logic                 rsp_zero,
    output logic                 rsp_err,
    output logic [2:0]           rsp_cmp,
    output logic [7:0]           op_count
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_DIV = 3'b111;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic               r_req_ready;
    logic               w_accept;
    logic               w_rsp_hs;
    logic               w_div_zero;
    logic [2*WIDTH-1:0] w_cap_data;

    assign w_accept   = (r_state == IDLE) && req_valid && r_req_ready;
    assign w_rsp_hs   = (r_state == RESP) && rsp_valid && rsp_ready;
    assign w_div_zero = (alu_select == c_OP_DIV) && (alu_b == '0);
    // Divide-by-zero results from the ALU are undefined; report zero instead.
    assign w_cap_data = w_div_zero ? '0 : alu_out;

    assign req_ready  = r_req_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = EXEC;
            EXEC:    w_state_next = RESP;
            RESP:    if (w_rsp_hs) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // req_ready is registered from the next state so that it stays low while
    // reset is held and only rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_req_ready <= (w_state_next == IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_select <= 3'b000;
        end else if (w_accept) begin
            alu_a      <= req_a;
            alu_b      <= req_b;
            alu_select <= req_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_zero  <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_cmp   <= 3'b000;
        end else if (r_state == EXEC) begin
            rsp_valid <= 1'b1;
            rsp_data  <= w_cap_data;
            rsp_carry <= (alu_select == c_OP_ADD) ? alu_carry : 1'b0;
            rsp_zero  <= (w_cap_data == '0);
            rsp_err   <= w_div_zero;
            rsp_cmp   <= {alu_greater, alu_equal, alu_less};
        end else if (w_rsp_hs) begin
            rsp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= 8'd0;
        end else if (w_rsp_hs) begin
            op_count <= op_count + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_sequencer
// Purpose  : Scoreboard bench for alu_sequencer with WIDTH=4. Includes a
//            behavioural stand-in for the external combinational ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           req_valid;
    logic           req_ready;
    logic [W-1:0]   req_a;
    logic [W-1:0]   req_b;
    logic [2:0]     req_op;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [2:0]     alu_select;
    logic [2*W-1:0] alu_out;
    logic           alu_carry;
    logic           alu_greater;
    logic           alu_equal;
    logic           alu_less;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [2*W-1:0] rsp_data;
    logic           rsp_carry;
    logic           rsp_zero;
    logic           rsp_err;
    logic [2:0]     rsp_cmp;
    logic [7:0]     op_count;

    alu_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
        .alu_out(alu_out), .alu_carry(alu_carry),
        .alu_greater(alu_greater), .alu_equal(alu_equal), .alu_less(alu_less),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero),
        .rsp_err(rsp_err), .rsp_cmp(rsp_cmp), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // External ALU stand-in. Carry is always the add carry so that the
    // sequencer must mask it for other ops; divide by zero returns junk.
    logic [W:0] w_sum;
    always_comb begin
        w_sum       = {1'b0, alu_a} + {1'b0, alu_b};
        alu_carry   = w_sum[W];
        alu_greater = (alu_a > alu_b);
        alu_equal   = (alu_a == alu_b);
        alu_less    = (alu_a < alu_b);
        alu_out     = '0;
        case (alu_select)
            3'b000: alu_out = {{(W-1){1'b0}}, w_sum};
            3'b001: alu_out = {{W{1'b0}}, alu_a - alu_b};
            3'b010: alu_out = {{W{1'b0}}, alu_a & alu_b};
            3'b011: alu_out = {{W{1'b0}}, alu_a | alu_b};
            3'b100: alu_out = {{W{1'b0}}, alu_a ^ alu_b};
            3'b101: alu_out = {{(2*W-1){1'b0}}, alu_a == alu_b};
            3'b110: alu_out = {{W{1'b0}}, alu_a} * {{W{1'b0}}, alu_b};
            default: alu_out = (alu_b == '0) ? 8'hA5 : {{W{1'b0}}, alu_a / alu_b};
        endcase
    end

    typedef struct packed {
        logic [7:0] data;
        logic       carry;
        logic       zero;
        logic       err;
        logic [2:0] cmp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_resp   = 0;
    bit   rand_ready = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference response computed from the operation definitions with
    // plain integer arithmetic.
    function automatic exp_t model(input logic [2:0] op, input int a, input int b);
        exp_t e;
        int   d;
        e.carry = 1'b0;
        e.err   = 1'b0;
        case (op)
            3'd0: begin d = a + b; e.carry = (a + b) > 15; end
            3'd1: d = (a - b + 16) % 16;
            3'd2: d = a & b;
            3'd3: d = a | b;
            3'd4: d = a ^ b;
            3'd5: d = (a == b) ? 1 : 0;
            3'd6: d = a * b;
            default: begin
                if (b == 0) begin d = 0; e.err = 1'b1; end
                else d = a / b;
            end
        endcase
        e.data = 8'(d);
        e.zero = (d == 0);
        e.cmp  = {a > b, a == b, a < b};
        return e;
    endfunction

    // Issue one command; caller is at posedge+2. Returns at posedge+2 after
    // the response became valid (or after a timeout).
    task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        bit ok = 0;
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
        end else begin
            sb_q.push_back(model(op, int'(a), int'(b)));
            @(posedge clk); #1;
            chk("alu_a", 32'(alu_a), 32'(a));
            chk("alu_b", 32'(alu_b), 32'(b));
            chk("alu_select", 32'(alu_select), 32'(op));
            chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("exec_req_ready", 32'(req_ready), 32'd0);
            #1;
            req_valid = 1'b0;
            req_a = 4'($urandom); req_b = 4'($urandom); req_op = 3'($urandom);
            @(posedge clk); #1;
            chk("latency_rsp_valid", 32'(rsp_valid), 32'd1);
            #1;
        end
    endtask

    // Random response backpressure, changed away from the sampling edge.
    initial begin
        forever begin
            @(posedge clk); #2;
            if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops the scoreboard on every response handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_response", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                    chk("rsp_carry", 32'(rsp_carry), 32'(e.carry));
                    chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    chk("rsp_cmp", 32'(rsp_cmp), 32'(e.cmp));
                end
                @(posedge clk); #1;
                n_resp++;
                chk("op_count", 32'(op_count), 32'(n_resp % 256));
                chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        chk({tag, "_rsp_flags"}, 32'({rsp_carry, rsp_zero, rsp_err, rsp_cmp}), 32'd0);
        chk({tag, "_alu_regs"}, 32'({alu_a, alu_b, alu_select}), 32'd0);
        chk({tag, "_op_count"}, 32'(op_count), 32'd0);
    endtask

    initial begin
        logic [7:0] held;
        bit         done;
        rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk); #2 rst_n = 1'b1;
        #1 chk("post_release_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("first_edge_ready", 32'(req_ready), 32'd1);
        #1;

        // Reset during EXEC aborts the command.
        req_op = 3'd0; req_a = 4'd5; req_b = 4'd6; req_valid = 1'b1;
        @(negedge clk);
        chk("abort_accept_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("abort");
        @(negedge clk); #1 rst_n = 1'b1;
        #1 chk("abort_release_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("abort_first_edge_ready", 32'(req_ready), 32'd1);
        chk("abort_op_count", 32'(op_count), 32'd0);
        #1;

        // Directed operations.
        issue(3'd0, 4'd9, 4'd8);
        issue(3'd6, 4'd15, 4'd15);
        issue(3'd1, 4'd3, 4'd5);
        issue(3'd7, 4'd7, 4'd0);
        issue(3'd7, 4'd7, 4'd2);
        issue(3'd5, 4'd4, 4'd4);
        issue(3'd4, 4'd12, 4'd10);

        // Backpressure: response held for 5 cycles, stray request ignored.
        @(posedge clk); #2 rsp_ready = 1'b0;
        issue(3'd3, 4'd9, 4'd6);
        held = rsp_data;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_a = 4'd1; req_b = 4'd2; req_op = 3'd2;
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_data", 32'(rsp_data), 32'(held));
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #2;
        end
        req_valid = 1'b0;
        chk("bp_no_accept", 32'({alu_a, alu_b, alu_select}), 32'({4'd9, 4'd6, 3'd3}));
        rsp_ready = 1'b1;

        // Random traffic until 256 responses have completed.
        rand_ready = 1;
        for (int i = 8; i < 256; i++)
            issue(3'($urandom), 4'($urandom), 4'($urandom));
        done = 0;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk);
            if (n_resp >= 256) begin done = 1; break; end
        end
        #3;
        if (!done) chk("drain_timeout", 32'(n_resp), 32'd256);
        chk("wrap_op_count", 32'(op_count), 32'd0);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        rand_ready = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got n_resp=%0d expected 256", n_resp);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width; the result width is 2*WIDTH.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have ports req_valid (input, 1), req_ready (output, 1), req_a (input, WIDTH), req_b (input, WIDTH) and req_op (input, 3) forming the command channel; req_op uses the ALU select encoding: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 equal, 110 mul, 111 div.
REQ-005 The block SHALL have ports alu_a (output, WIDTH), alu_b (output, WIDTH) and alu_select (output, 3), all registered, driving the combinational ALU.
REQ-006 The block SHALL have ports alu_out (input, 2*WIDTH) and alu_carry, alu_greater, alu_equal, alu_less (inputs, 1 each) returning the ALU results.
REQ-007 The block SHALL have ports rsp_valid (output, 1) and rsp_ready (input, 1) forming the response handshake.
REQ-008 The block SHALL have response outputs rsp_data (2*WIDTH), rsp_carry (1), rsp_zero (1), rsp_err (1) and rsp_cmp (3, {greater, equal, less}).
REQ-009 The block SHALL have port op_count, output, 8 bits, the count of completed responses.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-011 req_ready SHALL be 1 only in IDLE, and 0 in EXEC and RESP.
REQ-012 In IDLE, req_valid && req_ready at a clock edge SHALL register req_a, req_b and req_op into alu_a, alu_b and alu_select, and move the FSM to EXEC.
REQ-013 In IDLE without req_valid, the FSM SHALL remain in IDLE and the alu_* registers SHALL hold their values.
REQ-014 EXEC SHALL last exactly one cycle; at its ending edge the block SHALL capture the results and move to RESP.
REQ-015 Capture into rsp_data SHALL be alu_out, except for div with alu_b == 0, where rsp_data SHALL be 0.
REQ-016 Capture into rsp_carry SHALL be alu_carry when alu_select == 000, else 0.
REQ-017 Capture into rsp_cmp SHALL be {alu_greater, alu_equal, alu_less} for every op.
REQ-018 Capture into rsp_err SHALL be 1 if and only if alu_select == 111 and alu_b == 0.
REQ-019 Capture into rsp_zero SHALL be 1 if and only if the captured rsp_data == 0, including the error case.
REQ-020 rsp_valid SHALL be 1 only in RESP, so rsp_valid rises on the first edge after the accepting edge (latency 1 cycle after acceptance).
REQ-021 In RESP, all rsp_* outputs SHALL be held stable until rsp_valid && rsp_ready.
REQ-022 On rsp_valid && rsp_ready, the FSM SHALL return to IDLE, op_count SHALL increment by 1 (wrapping 255 -> 0), and rsp_valid SHALL drop on the same edge.
REQ-023 A new request SHALL NOT be accepted on the same edge as a response handshake; the minimum request spacing is 3 cycles.
REQ-024 If rsp_ready is already 1 on entering RESP, the handshake SHALL complete at the next edge, so rsp_valid is high for exactly 1 cycle.
REQ-025 Sub and logic results SHALL appear zero-extended in rsp_data as supplied by the ALU; the block SHALL NOT re-extend or sign-extend them.

Reset
REQ-026 Assertion of rst_n = 0 SHALL, asynchronously and in any state, force the FSM to IDLE.
REQ-027 While reset is asserted, req_ready SHALL be 0, and SHALL become 1 on the first edge after deassertion.
REQ-028 Reset SHALL clear rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_err, rsp_cmp, alu_a, alu_b, alu_select and op_count to 0.
REQ-029 A reset asserted during EXEC or RESP SHALL abort the operation without a response and without incrementing op_count.

Verification
REQ-030 The bench SHALL cover, with WIDTH=4: add a=9, b=8 -> rsp_valid 1 cycle after accept; rsp_data=0x11, rsp_carry=1, rsp_zero=0, rsp_cmp=100.
REQ-031 The bench SHALL cover, with WIDTH=4: mul a=15, b=15 -> rsp_data=0xE1, rsp_carry=0, rsp_err=0; sub a=3, b=5 -> rsp_data=0x0E, rsp_cmp=001.
REQ-032 The bench SHALL cover, with WIDTH=4: div a=7, b=0 -> rsp_err=1, rsp_data=0x00, rsp_zero=1; the following div a=7, b=2 -> rsp_data=0x03, rsp_err=0.
REQ-033 The bench SHALL cover backpressure: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_data stable, req_ready=0, and a request presented during that time is not accepted.
REQ-034 The bench SHALL cover reset mid-operation: rst_n pulsed low during EXEC -> immediately rsp_valid=0, req_ready=0, all outputs 0; req_ready=1 on the first edge after release; op_count unchanged at 0.
REQ-035 The bench SHALL cover op_count wrap: 256 complete transactions -> op_count reads 255 after the 255th and 0 after the 256th.
